// File: rtl/irig_frame_sequencer_if.sv
// Bundle between the IRIG-B pulse classifier, the frame sequencer and the timestamp accumulator.
// IRIG_CTRL_CAPTURE_EN adds the 18-bit control-function capture bus.
interface irig_frame_sequencer_if #(
    parameter int ERR_CNT_W = 8
) ();
    logic                 sym_valid;
    logic [1:0]           sym;
    logic [2:0]           ts_select;
    logic                 ts_reset;
    logic [4:0]           bit_idx;
    logic [1:0]           digit_idx;
    logic                 bit_value;
    logic                 frame_done;
    logic                 frame_err;
    logic                 locked;
    logic [ERR_CNT_W-1:0] err_count;

`ifdef IRIG_CTRL_CAPTURE_EN
    logic [17:0]          ctrl_bits;

    modport master (
        input  sym_valid, sym,
        output ts_select, ts_reset, bit_idx, digit_idx, bit_value,
        output frame_done, frame_err, locked, err_count, ctrl_bits
    );
    modport slave (
        output sym_valid, sym,
        input  ts_select, ts_reset, bit_idx, digit_idx, bit_value,
        input  frame_done, frame_err, locked, err_count, ctrl_bits
    );
`else
    modport master (
        input  sym_valid, sym,
        output ts_select, ts_reset, bit_idx, digit_idx, bit_value,
        output frame_done, frame_err, locked, err_count
    );
    modport slave (
        output sym_valid, sym,
        input  ts_select, ts_reset, bit_idx, digit_idx, bit_value,
        input  frame_done, frame_err, locked, err_count
    );
`endif
endinterface

// File: rtl/irig_frame_sequencer.sv
// IRIG-B frame sync and bit-position tracker that steers data bits into the timestamp accumulator.
// Control-function capture (ctrl_bits) is built only when IRIG_CTRL_CAPTURE_EN is defined.
module irig_frame_sequencer #(
    parameter int LOCK_FRAMES = 2,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    irig_frame_sequencer_if.master if_seq
);
    localparam logic [1:0]           SYM_MARK = 2'b10;
    localparam logic [1:0]           SYM_BAD  = 2'b11;
    localparam logic [3:0]           GOOD_MAX = 4'(LOCK_FRAMES);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;
    localparam logic [ERR_CNT_W-1:0] ERR_ONE  = ERR_CNT_W'(1);

    // HUNT: wait for any marker | MARK1: next marker is Pr | FRAME: tracking positions 1..99
    typedef enum logic [1:0] {S_HUNT, S_MARK1, S_FRAME} state_t;

    state_t               r_state, w_state_nx;
    logic [6:0]           r_pos, w_pos_nx, w_pos_inc, w_map_lo;
    logic [3:0]           r_good, w_good_nx;
    logic [ERR_CNT_W-1:0] r_err_cnt, w_err_cnt_nx;
    logic                 r_armed, r_locked, w_accept, w_is_pslot;
    logic [2:0]           r_sel, w_sel_nx, w_map_sel;
    logic [4:0]           r_bidx, w_bidx_nx, w_map_bit;
    logic [1:0]           r_didx, w_didx_nx, w_map_dig;
    logic                 r_bval, w_bval_nx, r_ts_rst, w_ts_rst_nx;
    logic                 r_done, w_done_nx, r_ferr, w_ferr_nx;
`ifdef IRIG_CTRL_CAPTURE_EN
    logic [17:0]          r_ctrl_live, r_ctrl_hold;
    logic                 w_ctrl_we;
    logic [4:0]           w_ctrl_idx;
`endif

    function automatic logic in_rng(input logic [6:0] p, input logic [6:0] lo, input logic [6:0] hi);
        return (p >= lo) && (p <= hi);
    endfunction

    // r_armed drops the strobe that coincides with the first edge after reset release
    assign w_accept   = if_seq.sym_valid & r_armed;
    assign w_pos_inc  = r_pos + 7'd1;
    assign w_is_pslot = w_pos_inc inside {7'd9, 7'd19, 7'd29, 7'd39, 7'd49,
                                          7'd59, 7'd69, 7'd79, 7'd89, 7'd99};
    assign w_map_bit  = 5'(w_pos_inc - w_map_lo);

    always_comb begin
        w_map_sel = 3'd0;
        w_map_dig = 2'd0;
        w_map_lo  = 7'd0;
        if      (in_rng(w_pos_inc, 7'd1,  7'd4 )) begin w_map_sel = 3'd1; w_map_lo = 7'd1;  end
        else if (in_rng(w_pos_inc, 7'd6,  7'd8 )) begin w_map_sel = 3'd1; w_map_dig = 2'd1; w_map_lo = 7'd6;  end
        else if (in_rng(w_pos_inc, 7'd10, 7'd13)) begin w_map_sel = 3'd2; w_map_lo = 7'd10; end
        else if (in_rng(w_pos_inc, 7'd15, 7'd17)) begin w_map_sel = 3'd2; w_map_dig = 2'd1; w_map_lo = 7'd15; end
        else if (in_rng(w_pos_inc, 7'd20, 7'd23)) begin w_map_sel = 3'd3; w_map_lo = 7'd20; end
        else if (in_rng(w_pos_inc, 7'd25, 7'd26)) begin w_map_sel = 3'd3; w_map_dig = 2'd1; w_map_lo = 7'd25; end
        else if (in_rng(w_pos_inc, 7'd30, 7'd33)) begin w_map_sel = 3'd4; w_map_lo = 7'd30; end
        else if (in_rng(w_pos_inc, 7'd35, 7'd38)) begin w_map_sel = 3'd4; w_map_dig = 2'd1; w_map_lo = 7'd35; end
        else if (in_rng(w_pos_inc, 7'd40, 7'd41)) begin w_map_sel = 3'd4; w_map_dig = 2'd2; w_map_lo = 7'd40; end
        else if (in_rng(w_pos_inc, 7'd50, 7'd53)) begin w_map_sel = 3'd5; w_map_lo = 7'd50; end
        else if (in_rng(w_pos_inc, 7'd55, 7'd58)) begin w_map_sel = 3'd5; w_map_dig = 2'd1; w_map_lo = 7'd55; end
        else if (in_rng(w_pos_inc, 7'd80, 7'd88)) begin w_map_sel = 3'd6; w_map_lo = 7'd80; end
        else if (in_rng(w_pos_inc, 7'd90, 7'd97)) begin w_map_sel = 3'd6; w_map_lo = 7'd81; end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_pos_nx     = r_pos;
        w_good_nx    = r_good;
        w_err_cnt_nx = r_err_cnt;
        w_sel_nx     = 3'd0;
        w_ts_rst_nx  = 1'b0;
        w_done_nx    = 1'b0;
        w_ferr_nx    = 1'b0;
        w_bidx_nx    = r_bidx;
        w_didx_nx    = r_didx;
        w_bval_nx    = r_bval;
`ifdef IRIG_CTRL_CAPTURE_EN
        w_ctrl_we    = 1'b0;
        w_ctrl_idx   = 5'd0;
`endif
        if (w_accept) begin
            w_bidx_nx = 5'd0;
            w_didx_nx = 2'd0;
            w_bval_nx = 1'b0;
            case (r_state)
                S_HUNT: begin
                    if (if_seq.sym == SYM_MARK) w_state_nx = S_MARK1;
                end
                S_MARK1: begin
                    if (if_seq.sym == SYM_MARK) begin
                        w_state_nx  = S_FRAME;
                        w_pos_nx    = 7'd0;
                        w_ts_rst_nx = 1'b1;
                    end else begin
                        w_state_nx  = S_HUNT;
                    end
                end
                S_FRAME: begin
                    w_pos_nx = w_pos_inc;
                    if ((if_seq.sym == SYM_BAD) || ((if_seq.sym == SYM_MARK) != w_is_pslot)) begin
                        w_state_nx = S_HUNT;
                        w_ferr_nx  = 1'b1;
                        w_good_nx  = 4'd0;
                        if (r_err_cnt != ERR_MAX) w_err_cnt_nx = r_err_cnt + ERR_ONE;
                    end else if (w_is_pslot) begin
                        if (w_pos_inc == 7'd99) begin
                            w_state_nx = S_MARK1;
                            w_done_nx  = 1'b1;
                            if (r_good != GOOD_MAX) w_good_nx = r_good + 4'd1;
                        end
                    end else if (w_map_sel != 3'd0) begin
                        w_sel_nx  = w_map_sel;
                        w_didx_nx = w_map_dig;
                        w_bidx_nx = w_map_bit;
                        w_bval_nx = if_seq.sym[0];
                    end
`ifdef IRIG_CTRL_CAPTURE_EN
                    if (!w_ferr_nx && in_rng(w_pos_inc, 7'd60, 7'd68)) begin
                        w_ctrl_we  = 1'b1;
                        w_ctrl_idx = 5'(w_pos_inc - 7'd60);
                    end else if (!w_ferr_nx && in_rng(w_pos_inc, 7'd70, 7'd78)) begin
                        w_ctrl_we  = 1'b1;
                        w_ctrl_idx = 5'(w_pos_inc - 7'd61);
                    end
`endif
                end
                default: w_state_nx = S_HUNT;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_armed   <= 1'b0;
            r_state   <= S_HUNT;
            r_pos     <= 7'd0;
            r_good    <= 4'd0;
            r_err_cnt <= '0;
            r_locked  <= 1'b0;
            r_sel     <= 3'd0;
            r_ts_rst  <= 1'b0;
            r_bidx    <= 5'd0;
            r_didx    <= 2'd0;
            r_bval    <= 1'b0;
            r_done    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_armed   <= 1'b1;
            r_state   <= w_state_nx;
            r_pos     <= w_pos_nx;
            r_good    <= w_good_nx;
            r_err_cnt <= w_err_cnt_nx;
            r_locked  <= (w_good_nx == GOOD_MAX);
            r_sel     <= w_sel_nx;
            r_ts_rst  <= w_ts_rst_nx;
            r_bidx    <= w_bidx_nx;
            r_didx    <= w_didx_nx;
            r_bval    <= w_bval_nx;
            r_done    <= w_done_nx;
            r_ferr    <= w_ferr_nx;
        end
    end

`ifdef IRIG_CTRL_CAPTURE_EN
    // Live bits fill during the frame; the held copy only changes on a completed frame
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ctrl_live <= '0;
            r_ctrl_hold <= '0;
        end else begin
            if (w_ctrl_we) r_ctrl_live[w_ctrl_idx] <= if_seq.sym[0];
            if (w_done_nx) r_ctrl_hold <= r_ctrl_live;
        end
    end

    assign if_seq.ctrl_bits = r_ctrl_hold;
`endif

    assign if_seq.ts_select  = r_sel;
    assign if_seq.ts_reset   = r_ts_rst;
    assign if_seq.bit_idx    = r_bidx;
    assign if_seq.digit_idx  = r_didx;
    assign if_seq.bit_value  = r_bval;
    assign if_seq.frame_done = r_done;
    assign if_seq.frame_err  = r_ferr;
    assign if_seq.locked     = r_locked;
    assign if_seq.err_count  = r_err_cnt;
endmodule

// File: tb/tb_irig_frame_sequencer.sv
// Scoreboard bench for irig_frame_sequencer: a reference model predicts every strobe, and a
// behavioural accumulator rebuilds the timestamp fields for decode checks.
module tb_irig_frame_sequencer;
    localparam int ERR_W   = 8;
    localparam int LOCK    = 2;
    localparam int ERR_SAT = (1 << ERR_W) - 1;
    localparam logic [1:0] MK  = 2'b10;
    localparam logic [1:0] BAD = 2'b11;

    typedef struct packed {
        logic [2:0]       sel;
        logic [4:0]       bidx;
        logic [1:0]       didx;
        logic             bval;
        logic             tsr;
        logic             fdone;
        logic             ferr;
        logic             lck;
        logic [ERR_W-1:0] errc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    irig_frame_sequencer_if #(.ERR_CNT_W(ERR_W)) ifc ();

    irig_frame_sequencer #(.LOCK_FRAMES(LOCK), .ERR_CNT_W(ERR_W)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .if_seq (ifc)
    );

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_state, m_pos, m_good, m_err;
    logic m_locked;
    logic tb_vq = 1'b0;

    logic [11:0] acc_f [1:5];
    logic [16:0] acc_sbs;

    // Behavioural accumulator fed by the DUT strobes
    always @(posedge clk) begin
        if (ifc.ts_reset) begin
            for (int i = 1; i <= 5; i++) acc_f[i] <= '0;
            acc_sbs <= '0;
        end else if (ifc.ts_select >= 3'd1 && ifc.ts_select <= 3'd5) begin
            acc_f[ifc.ts_select][int'(ifc.digit_idx) * 4 + int'(ifc.bit_idx)] <= ifc.bit_value;
        end else if (ifc.ts_select == 3'd6 && ifc.bit_idx <= 5'd16) begin
            acc_sbs[ifc.bit_idx] <= ifc.bit_value;
        end
    end

    always @(posedge clk) tb_vq <= ifc.sym_valid && rst_n;

    always @(negedge clk) begin
        if (tb_vq) begin
            if (sb_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL sb_underflow: output cycle with no expectation queued");
            end else begin
                mon_e = sb_q.pop_front();
                n_cmp++;
                if ({ifc.ts_select, ifc.ts_reset, ifc.frame_done, ifc.frame_err, ifc.locked, ifc.err_count}
                    !== {mon_e.sel, mon_e.tsr, mon_e.fdone, mon_e.ferr, mon_e.lck, mon_e.errc}) begin
                    n_bad++;
                    $display("FAIL strobe_ctl pos=%0d got sel=%0d rst=%0b done=%0b err=%0b lck=%0b cnt=%0d exp sel=%0d rst=%0b done=%0b err=%0b lck=%0b cnt=%0d",
                             m_pos, ifc.ts_select, ifc.ts_reset, ifc.frame_done, ifc.frame_err, ifc.locked, ifc.err_count,
                             mon_e.sel, mon_e.tsr, mon_e.fdone, mon_e.ferr, mon_e.lck, mon_e.errc);
                end
                n_cmp++;
                if ({ifc.bit_idx, ifc.digit_idx} !== {mon_e.bidx, mon_e.didx} ||
                    (mon_e.sel != 3'd0 && ifc.bit_value !== mon_e.bval)) begin
                    n_bad++;
                    $display("FAIL strobe_data pos=%0d got bit=%0d dig=%0d val=%0b exp bit=%0d dig=%0d val=%0b",
                             m_pos, ifc.bit_idx, ifc.digit_idx, ifc.bit_value, mon_e.bidx, mon_e.didx, mon_e.bval);
                end
            end
        end else if (rst_n) begin
            n_cmp++;
            if ({ifc.ts_select, ifc.ts_reset, ifc.frame_done, ifc.frame_err} !== 6'd0) begin
                n_bad++;
                $display("FAIL idle_quiet got sel=%0d rst=%0b done=%0b err=%0b exp all 0",
                         ifc.ts_select, ifc.ts_reset, ifc.frame_done, ifc.frame_err);
            end
        end
    end

    function automatic void map_pos(input int p, output int sel, output int dig, output int bi);
        int t, u;
        t = p / 10; u = p % 10;
        sel = 0; dig = 0; bi = 0;
        case (t)
            0: if (u >= 1 && u <= 4) begin sel = 1; bi = u - 1; end
               else if (u >= 6 && u <= 8) begin sel = 1; dig = 1; bi = u - 6; end
            1: if (u <= 3) begin sel = 2; bi = u; end
               else if (u >= 5 && u <= 7) begin sel = 2; dig = 1; bi = u - 5; end
            2: if (u <= 3) begin sel = 3; bi = u; end
               else if (u == 5 || u == 6) begin sel = 3; dig = 1; bi = u - 5; end
            3: if (u <= 3) begin sel = 4; bi = u; end
               else if (u >= 5 && u <= 8) begin sel = 4; dig = 1; bi = u - 5; end
            4: if (u <= 1) begin sel = 4; dig = 2; bi = u; end
            5: if (u <= 3) begin sel = 5; bi = u; end
               else if (u >= 5 && u <= 8) begin sel = 5; dig = 1; bi = u - 5; end
            8: if (u <= 8) begin sel = 6; bi = u; end
            9: if (u <= 7) begin sel = 6; bi = 9 + u; end
            default: ;
        endcase
    endfunction

    task automatic model_reset();
        m_state = 0; m_pos = 0; m_good = 0; m_err = 0; m_locked = 1'b0;
    endtask

    task automatic model_step(input logic [1:0] s, output exp_t e);
        int np, sel, dig, bi;
        e = '0;
        case (m_state)
            0: if (s == MK) m_state = 1;
            1: if (s == MK) begin m_state = 2; m_pos = 0; e.tsr = 1'b1; end
               else m_state = 0;
            default: begin
                np = m_pos + 1;
                if (s == BAD || ((s == MK) != (np % 10 == 9))) begin
                    e.ferr = 1'b1; m_state = 0; m_good = 0;
                    if (m_err < ERR_SAT) m_err++;
                end else if (s == MK && np == 99) begin
                    e.fdone = 1'b1; m_state = 1;
                    if (m_good < LOCK) m_good++;
                end else if (s != MK) begin
                    map_pos(np, sel, dig, bi);
                    if (sel != 0) begin
                        e.sel = 3'(sel); e.didx = 2'(dig); e.bidx = 5'(bi); e.bval = s[0];
                    end
                end
                m_pos = np;
            end
        endcase
        m_locked = (m_good == LOCK);
        e.lck  = m_locked;
        e.errc = ERR_W'(m_err);
    endtask

    task automatic send_sym(input logic [1:0] s);
        exp_t e;
        @(negedge clk);
        model_step(s, e);
        sb_q.push_back(e);
        ifc.sym_valid = 1'b1;
        ifc.sym       = s;
        @(negedge clk);
        ifc.sym_valid = 1'b0;
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic int bcd_val(input logic [11:0] x);
        return int'(x[3:0]) + 10 * int'(x[7:4]) + 100 * int'(x[11:8]);
    endfunction

    // Sends positions 0..99 (Pr through P0); err_pos replaces that symbol, abort stops before it
    task automatic send_frame(input int sec, input int mn, input int hr, input int day, input int yr,
                              input int sbs, input logic [17:0] ctrl,
                              input int err_pos, input logic [1:0] err_sym, input bit abort);
        logic [99:0] d;
        logic [11:0] b;
        logic [16:0] sv;
        logic [1:0]  s;
        d = '0;
        b = to_bcd(sec); for (int i = 0; i < 4; i++) d[1 + i]  = b[i]; for (int i = 0; i < 3; i++) d[6 + i]  = b[4 + i];
        b = to_bcd(mn);  for (int i = 0; i < 4; i++) d[10 + i] = b[i]; for (int i = 0; i < 3; i++) d[15 + i] = b[4 + i];
        b = to_bcd(hr);  for (int i = 0; i < 4; i++) d[20 + i] = b[i]; for (int i = 0; i < 2; i++) d[25 + i] = b[4 + i];
        b = to_bcd(day); for (int i = 0; i < 4; i++) d[30 + i] = b[i]; for (int i = 0; i < 4; i++) d[35 + i] = b[4 + i];
        for (int i = 0; i < 2; i++) d[40 + i] = b[8 + i];
        b = to_bcd(yr);  for (int i = 0; i < 4; i++) d[50 + i] = b[i]; for (int i = 0; i < 4; i++) d[55 + i] = b[4 + i];
        sv = 17'(sbs);
        for (int i = 0; i < 9; i++) d[80 + i] = sv[i];
        for (int i = 0; i < 8; i++) d[90 + i] = sv[9 + i];
        for (int i = 0; i < 9; i++) d[60 + i] = ctrl[i];
        for (int i = 0; i < 9; i++) d[70 + i] = ctrl[9 + i];
        for (int p = 0; p < 100; p++) begin
            s = (p == 0 || p % 10 == 9) ? MK : {1'b0, d[p]};
            if (p == err_pos) begin
                if (!abort) send_sym(err_sym);
                return;
            end
            send_sym(s);
        end
    endtask

    task automatic test_reset();
        exp_t e;
        model_reset();
        ifc.sym_valid = 1'b0;
        ifc.sym       = 2'b00;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({ifc.ts_select, ifc.ts_reset, ifc.bit_idx, ifc.digit_idx, ifc.bit_value, ifc.frame_done,
             ifc.frame_err, ifc.locked, ifc.err_count} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got sel=%0d rst=%0b bit=%0d dig=%0d done=%0b err=%0b lck=%0b cnt=%0d exp all 0",
                     ifc.ts_select, ifc.ts_reset, ifc.bit_idx, ifc.digit_idx, ifc.frame_done, ifc.frame_err,
                     ifc.locked, ifc.err_count);
        end
        // Marker presented on the release cycle must be ignored
        @(negedge clk);
        rst_n = 1'b1;
        e = '0;
        sb_q.push_back(e);
        ifc.sym_valid = 1'b1;
        ifc.sym       = MK;
        @(negedge clk);
        ifc.sym_valid = 1'b0;
        send_sym(MK);
        send_sym(2'b00);
        send_sym(MK);
        send_sym(BAD);
    endtask

    task automatic test_clean_lock();
        send_sym(MK);
        send_frame(0, 0, 0, 1, 0, 0, 18'h0, -1, 2'b00, 1'b0);
        n_cmp++;
        if (bcd_val(acc_f[4]) != 1) begin
            n_bad++; $display("FAIL clean_day got=%0d exp=1", bcd_val(acc_f[4]));
        end
        n_cmp++;
        if (ifc.locked !== 1'b0) begin
            n_bad++; $display("FAIL lock_after_1 got=%0b exp=0", ifc.locked);
        end
        send_frame(0, 0, 0, 1, 0, 0, 18'h0, -1, 2'b00, 1'b0);
        n_cmp++;
        if (ifc.locked !== 1'b1) begin
            n_bad++; $display("FAIL lock_after_2 got=%0b exp=1", ifc.locked);
        end
    endtask

    task automatic check_decode(input int sec, input int mn, input int hr, input int day, input int yr, input int sbs);
        n_cmp++;
        if (bcd_val(acc_f[1]) != sec) begin n_bad++; $display("FAIL dec_sec got=%0d exp=%0d", bcd_val(acc_f[1]), sec); end
        n_cmp++;
        if (bcd_val(acc_f[2]) != mn)  begin n_bad++; $display("FAIL dec_min got=%0d exp=%0d", bcd_val(acc_f[2]), mn); end
        n_cmp++;
        if (bcd_val(acc_f[3]) != hr)  begin n_bad++; $display("FAIL dec_hr got=%0d exp=%0d", bcd_val(acc_f[3]), hr); end
        n_cmp++;
        if (bcd_val(acc_f[4]) != day) begin n_bad++; $display("FAIL dec_day got=%0d exp=%0d", bcd_val(acc_f[4]), day); end
        n_cmp++;
        if (bcd_val(acc_f[5]) != yr)  begin n_bad++; $display("FAIL dec_yr got=%0d exp=%0d", bcd_val(acc_f[5]), yr); end
        n_cmp++;
        if (int'(acc_sbs) != sbs)     begin n_bad++; $display("FAIL dec_sbs got=%0d exp=%0d", acc_sbs, sbs); end
    endtask

    task automatic test_decode();
        send_frame(56, 34, 12, 256, 25, 45296, 18'h2A5C3, -1, 2'b00, 1'b0);
        check_decode(56, 34, 12, 256, 25, 45296);
        n_cmp++;
        if (ifc.locked !== 1'b1) begin n_bad++; $display("FAIL lock_held got=%0b exp=1", ifc.locked); end
`ifdef IRIG_CTRL_CAPTURE_EN
        n_cmp++;
        if (ifc.ctrl_bits !== 18'h2A5C3) begin
            n_bad++; $display("FAIL ctrl_capture got=%h exp=%h", ifc.ctrl_bits, 18'h2A5C3);
        end
`endif
    endtask

    task automatic test_marker_mid();
        send_frame(1, 2, 3, 4, 5, 6, 18'h0, 45, MK, 1'b0);
        n_cmp++;
        if (ifc.err_count !== ERR_W'(1)) begin n_bad++; $display("FAIL mid_err_count got=%0d exp=1", ifc.err_count); end
        n_cmp++;
        if (ifc.locked !== 1'b0) begin n_bad++; $display("FAIL mid_unlock got=%0b exp=0", ifc.locked); end
    endtask

    task automatic test_pslot_relock();
        send_sym(MK);
        send_frame(9, 8, 7, 6, 5, 4, 18'h3FFFF, 59, 2'b01, 1'b0);
        n_cmp++;
        if (ifc.err_count !== ERR_W'(2)) begin n_bad++; $display("FAIL pslot_err_count got=%0d exp=2", ifc.err_count); end
`ifdef IRIG_CTRL_CAPTURE_EN
        n_cmp++;
        if (ifc.ctrl_bits !== 18'h2A5C3) begin
            n_bad++; $display("FAIL ctrl_hold_on_err got=%h exp=%h", ifc.ctrl_bits, 18'h2A5C3);
        end
`endif
        send_sym(MK);
        send_frame(10, 20, 23, 365, 99, 86399, 18'h155AA, -1, 2'b00, 1'b0);
        n_cmp++;
        if (ifc.locked !== 1'b0) begin n_bad++; $display("FAIL relock_1 got=%0b exp=0", ifc.locked); end
        check_decode(10, 20, 23, 365, 99, 86399);
        send_frame(11, 20, 23, 365, 99, 86400, 18'h0, -1, 2'b00, 1'b0);
        n_cmp++;
        if (ifc.locked !== 1'b1) begin n_bad++; $display("FAIL relock_2 got=%0b exp=1", ifc.locked); end
    endtask

    task automatic test_reset_mid();
        send_frame(0, 0, 0, 0, 0, 0, 18'h0, 50, 2'b00, 1'b1);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({ifc.ts_select, ifc.ts_reset, ifc.frame_done, ifc.frame_err, ifc.locked, ifc.err_count} !== '0) begin
            n_bad++;
            $display("FAIL midrst_outputs got sel=%0d rst=%0b done=%0b err=%0b lck=%0b cnt=%0d exp all 0",
                     ifc.ts_select, ifc.ts_reset, ifc.frame_done, ifc.frame_err, ifc.locked, ifc.err_count);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send_sym(MK);
        send_frame(56, 34, 12, 256, 25, 45296, 18'h0, -1, 2'b00, 1'b0);
        check_decode(56, 34, 12, 256, 25, 45296);
    endtask

    task automatic test_err_saturate();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < ERR_SAT; k++) begin
            send_sym(MK);
            send_sym(MK);
            send_sym(BAD);
        end
        n_cmp++;
        if (ifc.err_count !== ERR_W'(ERR_SAT)) begin
            n_bad++; $display("FAIL err_reach_max got=%0d exp=%0d", ifc.err_count, ERR_SAT);
        end
        send_sym(MK);
        send_sym(MK);
        send_sym(BAD);
        n_cmp++;
        if (ifc.err_count !== ERR_W'(ERR_SAT)) begin
            n_bad++; $display("FAIL err_saturate got=%0d exp=%0d", ifc.err_count, ERR_SAT);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean_lock();
        test_decode();
        test_marker_mid();
        test_pslot_relock();
        test_reset_mid();
        test_err_saturate();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++; $display("FAIL sb_leftover got=%0d exp=0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
